// File: rtl/counter_pkg.sv
// counter_pkg
//   Shared definitions for the parametrised up/down counter.
//   - CNT_UP / CNT_DOWN : encoding of the dir_i input.
//   - cnt_op_e          : operation selected for the next count value.
package counter_pkg;

    // Direction encoding carried on dir_i.
    localparam logic CNT_UP   = 1'b1;
    localparam logic CNT_DOWN = 1'b0;

    // Next-state operation, resolved from rst_i > load_i > en_i priority.
    typedef enum logic [2:0] {
        HOLD  = 3'd0,
        LOAD  = 3'd1,
        INC   = 3'd2,
        DEC   = 3'd3,
        RESET = 3'd4
    } cnt_op_e;

endpackage : counter_pkg

// File: rtl/ripple_adder_n.sv
// ripple_adder_n
//   Parametrised ripple-carry adder built from a chain of full adders.
//   Ports:
//     X   [WIDTH-1:0] in  : first operand
//     Y   [WIDTH-1:0] in  : second operand
//     Cin             in  : carry into bit 0
//     S   [WIDTH-1:0] out : sum
//     Co              out : carry out of the top bit
module ripple_adder_n #(
    parameter int unsigned WIDTH = 32'd4
) (
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Co
);

    // carry_s[i] is the carry into bit i; carry_s[WIDTH] is the final carry.
    logic [WIDTH:0] carry_s;

    assign carry_s[0] = Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        logic prop_s;
        assign prop_s         = X[i] ^ Y[i];
        assign S[i]           = prop_s ^ carry_s[i];
        assign carry_s[i + 1] = (X[i] & Y[i]) | (prop_s & carry_s[i]);
    end

    assign Co = carry_s[WIDTH];

endmodule : ripple_adder_n

// File: rtl/updown_counter_n.sv
// updown_counter_n
//   Parametrised modular up/down counter with enable, synchronous parallel
//   load (clamped to MAX_VAL), combinational terminal count and a registered
//   one-cycle wrap pulse. Increment and decrement values come from two
//   ripple adders; wrap detection compares against MAX_VAL and 0, so moduli
//   that are not powers of two wrap correctly.
//
//   Compile-time option:
//     COUNTER_SAT_EN : when defined, the counter saturates at MAX_VAL (up)
//                      and 0 (down) instead of wrapping, and wrap_o stays 0.
//
//   Parameters:
//     WIDTH   : counter width in bits (>= 2)
//     MAX_VAL : highest count value (modulus - 1)
//     RST_VAL : value loaded by reset (<= MAX_VAL)
//   Ports:
//     clk_i      in             : clock, rising edge
//     rst_i      in             : synchronous active-high reset
//     en_i       in             : count enable
//     dir_i      in             : 1 = up, 0 = down
//     load_i     in             : synchronous parallel load
//     load_val_i in [WIDTH-1:0] : value to load
//     count_o    out[WIDTH-1:0] : current count (registered)
//     tc_o       out            : terminal count (combinational)
//     wrap_o     out            : registered pulse in the cycle after a wrap
module updown_counter_n
    import counter_pkg::*;
#(
    parameter int unsigned       WIDTH   = 32'd8,
    parameter logic [WIDTH-1:0]  MAX_VAL = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0]  RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             dir_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o,
    output logic             wrap_o
);

    localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_VAL = {WIDTH{1'b1}};

    logic [WIDTH-1:0] count_r;
    logic             wrap_r;

    logic [WIDTH-1:0] count_next_s;
    logic             wrap_next_s;
    cnt_op_e          op_s;

    logic [WIDTH-1:0] inc_sum_s;
    logic [WIDTH-1:0] dec_sum_s;
    logic             inc_co_s;
    logic             dec_co_s;
    logic [WIDTH-1:0] load_clamped_s;
    logic             at_max_s;
    logic             at_zero_s;

    // Carry-outs are deliberately ignored: boundaries are found by compare.
    logic             unused_carry_s;
    assign unused_carry_s = inc_co_s ^ dec_co_s;

    // Increment path: count + 0 + 1.
    ripple_adder_n #(
        .WIDTH (WIDTH)
    ) u_inc_adder (
        .X   (count_r),
        .Y   (ZERO_VAL),
        .Cin (1'b1),
        .S   (inc_sum_s),
        .Co  (inc_co_s)
    );

    // Decrement path: count + all-ones + 0, i.e. two's-complement minus one.
    ripple_adder_n #(
        .WIDTH (WIDTH)
    ) u_dec_adder (
        .X   (count_r),
        .Y   (ONES_VAL),
        .Cin (1'b0),
        .S   (dec_sum_s),
        .Co  (dec_co_s)
    );

    assign at_max_s  = (count_r == MAX_VAL);
    assign at_zero_s = (count_r == ZERO_VAL);

    // Clamp the parallel-load value into the legal count range.
    always_comb begin
        load_clamped_s = load_val_i;
        if (load_val_i > MAX_VAL) begin
            load_clamped_s = MAX_VAL;
        end else begin
            load_clamped_s = load_val_i;
        end
    end

    // Resolve the operation for this edge: reset, then load, then count.
    always_comb begin
        op_s = HOLD;
        if (rst_i) begin
            op_s = RESET;
        end else if (load_i) begin
            op_s = LOAD;
        end else if (en_i) begin
            if (dir_i == CNT_UP) begin
                op_s = INC;
            end else begin
                op_s = DEC;
            end
        end else begin
            op_s = HOLD;
        end
    end

    // Next count and wrap flag, including boundary wrap or saturation.
    always_comb begin
        count_next_s = count_r;
        wrap_next_s  = 1'b0;
        case (op_s)
            RESET: begin
                count_next_s = RST_VAL;
                wrap_next_s  = 1'b0;
            end
            LOAD: begin
                count_next_s = load_clamped_s;
                wrap_next_s  = 1'b0;
            end
            INC: begin
                if (at_max_s) begin
`ifdef COUNTER_SAT_EN
                    count_next_s = count_r;
                    wrap_next_s  = 1'b0;
`else
                    count_next_s = ZERO_VAL;
                    wrap_next_s  = 1'b1;
`endif
                end else begin
                    count_next_s = inc_sum_s;
                    wrap_next_s  = 1'b0;
                end
            end
            DEC: begin
                if (at_zero_s) begin
`ifdef COUNTER_SAT_EN
                    count_next_s = count_r;
                    wrap_next_s  = 1'b0;
`else
                    count_next_s = MAX_VAL;
                    wrap_next_s  = 1'b1;
`endif
                end else begin
                    count_next_s = dec_sum_s;
                    wrap_next_s  = 1'b0;
                end
            end
            HOLD: begin
                count_next_s = count_r;
                wrap_next_s  = 1'b0;
            end
            default: begin
                count_next_s = count_r;
                wrap_next_s  = 1'b0;
            end
        endcase
    end

    // Count and wrap registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_r <= RST_VAL;
            wrap_r  <= 1'b0;
        end else begin
            count_r <= count_next_s;
            wrap_r  <= wrap_next_s;
        end
    end

    assign count_o = count_r;
    // Terminal count is independent of load/reset so it can cascade en_i.
    assign tc_o    = en_i & ((dir_i == CNT_UP) ? at_max_s : at_zero_s);
`ifdef COUNTER_SAT_EN
    assign wrap_o  = 1'b0;
    logic unused_wrap_s;
    assign unused_wrap_s = wrap_r;
`else
    assign wrap_o  = wrap_r;
`endif

endmodule : updown_counter_n

// File: tb/tb_updown_counter_n.sv
// tb_updown_counter_n
//   Directed and randomised stimulus for two counters (RST_VAL 0 and 5,
//   WIDTH 4, MAX_VAL 9) checked against a modular-arithmetic reference model.
module tb_updown_counter_n;

    localparam int MAXV = 9;

    logic       clk;
    logic       rst;
    logic       en;
    logic       dir;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] count_a;
    logic       tc_a;
    logic       wrap_a;
    logic [3:0] count_b;
    logic       tc_b;
    logic       wrap_b;

    int checks = 0;
    int errors = 0;

    // Reference state for both instances.
    int m_cnt_a;
    int m_wrap_a;
    int m_cnt_b;
    int m_wrap_b;

    updown_counter_n #(
        .WIDTH   (32'd4),
        .MAX_VAL (4'd9),
        .RST_VAL (4'd0)
    ) dut_a (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .dir_i      (dir),
        .load_i     (load),
        .load_val_i (load_val),
        .count_o    (count_a),
        .tc_o       (tc_a),
        .wrap_o     (wrap_a)
    );

    updown_counter_n #(
        .WIDTH   (32'd4),
        .MAX_VAL (4'd9),
        .RST_VAL (4'd5)
    ) dut_b (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .dir_i      (dir),
        .load_i     (load),
        .load_val_i (load_val),
        .count_o    (count_b),
        .tc_o       (tc_b),
        .wrap_o     (wrap_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: next value from the current inputs, using modulo arithmetic.
    task automatic model_next(input int cnt, input int rv, output int ncnt, output int nwrap);
        bit sat;
`ifdef COUNTER_SAT_EN
        sat = 1'b1;
`else
        sat = 1'b0;
`endif
        nwrap = 0;
        if (rst) begin
            ncnt = rv;
        end else if (load) begin
            ncnt = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
        end else if (en && dir) begin
            if (cnt == MAXV && sat) ncnt = cnt;
            else begin
                ncnt  = (cnt + 1) % (MAXV + 1);
                nwrap = (cnt == MAXV) ? 1 : 0;
            end
        end else if (en) begin
            if (cnt == 0 && sat) ncnt = cnt;
            else begin
                ncnt  = (cnt + MAXV) % (MAXV + 1);
                nwrap = (cnt == 0) ? 1 : 0;
            end
        end else begin
            ncnt = cnt;
        end
    endtask

    function automatic int exp_tc(input int cnt);
        if (!en) return 0;
        return dir ? int'(cnt == MAXV) : int'(cnt == 0);
    endfunction

    // Compare every output of both instances with the reference.
    task automatic check_all(input string tag);
        chk({tag, ".count_a"}, 32'(count_a), 32'(m_cnt_a));
        chk({tag, ".wrap_a"},  32'(wrap_a),  32'(m_wrap_a));
        chk({tag, ".tc_a"},    32'(tc_a),    32'(exp_tc(m_cnt_a)));
        chk({tag, ".count_b"}, 32'(count_b), 32'(m_cnt_b));
        chk({tag, ".wrap_b"},  32'(wrap_b),  32'(m_wrap_b));
        chk({tag, ".tc_b"},    32'(tc_b),    32'(exp_tc(m_cnt_b)));
    endtask

    // Apply current inputs for one edge and advance the reference.
    task automatic step(input string tag);
        int na, wa, nb, wb;
        model_next(m_cnt_a, 0, na, wa);
        model_next(m_cnt_b, 5, nb, wb);
        @(posedge clk);
        #1;
        m_cnt_a = na; m_wrap_a = wa;
        m_cnt_b = nb; m_wrap_b = wb;
        check_all(tag);
    endtask

    task automatic drive(input logic r, input logic e, input logic d, input logic l, input logic [3:0] lv);
        rst = r; en = e; dir = d; load = l; load_val = lv;
    endtask

    initial begin
        m_cnt_a = 0; m_wrap_a = 0; m_cnt_b = 5; m_wrap_b = 0;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        #2;
        step("reset");
        step("reset2");
        chk("reset_lit_a", 32'(count_a), 32'd0);
        chk("reset_lit_b", 32'(count_b), 32'd5);

        // Count up through the wrap.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 12; i++) step("up");
        chk("up_end_lit", 32'(count_a), 32'd2);

        // Load 3 then count down through zero.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd3);
        step("load3");
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 5; i++) step("down");
        chk("down_end_lit", 32'(count_a), 32'd8);

        // Clamped load, then load beating a pending wrap.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd14);
        step("clamp");
        chk("clamp_lit", 32'(count_a), 32'd9);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd4);
        step("load_vs_wrap");
        chk("load_vs_wrap_lit", 32'({wrap_a, count_a}), 32'd4);

        // Direction toggling every cycle from 7, then hold.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd7);
        step("load7");
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, (i % 2 == 0) ? 1'b1 : 1'b0, 1'b0, 4'd0);
            step("toggle");
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++) step("hold");

        // Reset wins over a due wrap.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd9);
        step("load9");
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        step("rst_vs_wrap");
        chk("rst_vs_wrap_a", 32'({wrap_a, count_a}), 32'd0);
        chk("rst_vs_wrap_b", 32'({wrap_b, count_b}), 32'd5);

        // Saturation-boundary exercise (wraps in default build).
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd8);
        step("load8");
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++) step("sat_up");
        drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd1);
        step("load1");
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++) step("sat_down");

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(31) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(3) != 0) ? 1'b1 : 1'b0,
                  1'($urandom_range(1)),
                  ($urandom_range(7) == 0) ? 1'b1 : 1'b0,
                  4'($urandom_range(15)));
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_updown_counter_n
